// File: rtl/adder_operand_issuer.sv
// Purpose: buffers operand pairs and issues them to a registered adder; sum_valid marks real sums.
// Latency: push to earliest pop is 1 cycle; pop to A/B is 1 cycle; pop to sum_valid is LAT+1 cycles.
// Backpressure: in_ready drops when the FIFO holds DEPTH pairs; a same-cycle pop does not free a slot.
module adder_operand_issuer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     issue_en,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic                     sum_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              issued_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LAT:0]     vld_pipe;
  logic             push;
  logic             pop;
  pair_t            head_pair;

  // Handshake decode: ready comes only from the registered occupancy, held low during reset.
  always_comb begin
    in_ready  = reset & (count < CNT_W'(DEPTH));
    push      = in_valid & in_ready;
    pop       = issue_en & (count != '0);
    head_pair = mem[head];
    sum_valid = vld_pipe[LAT];
  end

  // Storage array; contents are meaningless while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{a: in_a, b: in_b};
    end
  end

  // Pointers and occupancy; full/empty decided by count alone, pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand registers feeding the adder; they hold their value when nothing is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A          <= '0;
      B          <= '0;
      issued_cnt <= '0;
    end else if (pop) begin
      A          <= head_pair.a;
      B          <= head_pair.b;
      issued_cnt <= issued_cnt + 16'd1;
    end
  end

  // Pop strobe delay line: one stage for the operand register plus LAT stages of adder latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= pop;
      for (int i = 1; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_issuer.sv
// Bench for adder_operand_issuer with a behavioural registered adder downstream.
// Table of per-cycle vectors plus hand sequences; a scoreboard queue pairs pushes with sum_valid.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_adder_operand_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       issue_en;
  logic [7:0] A;
  logic [7:0] B;
  logic       sum_valid;
  logic [2:0] count;
  logic [15:0] issued_cnt;
  logic [8:0] sum;

  int checks = 0;
  int errors = 0;

  logic [15:0] sbq [$];
  logic [7:0]  prev_a = 8'h00;
  logic [7:0]  prev_b = 8'h00;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       ie;
    int         cnt;
    logic       rdy;
    logic       sv;
    logic [7:0] ea;
    logic [7:0] eb;
    int         iss;
    logic [8:0] sm;
  } vec_t;

  vec_t tbl [24];

  adder_operand_issuer #(.WIDTH(8), .DEPTH(4), .LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .issue_en   (issue_en),
    .A          (A),
    .B          (B),
    .sum_valid  (sum_valid),
    .count      (count),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit registered adder, synchronous active-high reset driven by ~reset.
  always_ff @(posedge clk) begin
    if (!reset) sum <= 9'h000;
    else        sum <= {1'b0, A} + {1'b0, B};
  end

  function automatic vec_t mk(logic v, logic [7:0] a, logic [7:0] b, logic ie,
                              int cnt, logic rdy, logic sv, logic [7:0] ea,
                              logic [7:0] eb, int iss, logic [8:0] sm);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.ie = ie;
    r.cnt = cnt; r.rdy = rdy; r.sv = sv; r.ea = ea; r.eb = eb; r.iss = iss; r.sm = sm;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [7:0] a, logic [7:0] b, logic ie);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    issue_en = ie;
  endtask

  // Scoreboard step, run once per cycle at the falling edge.
  task automatic mon();
    logic [15:0] e;
    if (!reset) begin
      sbq.delete();
    end else begin
      if (sum_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sv_unexpected: sum_valid=1 with no pair outstanding, sum=%0h at %0t", sum, $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_a", 32'(prev_a), 32'(e[15:8]));
          chk("sb_b", 32'(prev_b), 32'(e[7:0]));
          chk("sb_sum", 32'(sum), 32'({1'b0, e[15:8]} + {1'b0, e[7:0]}));
        end
      end
      if (in_valid && in_ready) sbq.push_back({in_a, in_b});
    end
    prev_a = A;
    prev_b = B;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic fin();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] last_a;
    logic [7:0] last_b;

    // Single pair, then the four-deep fill with a held fifth pair, then carry cases.
    tbl[0]  = mk(1, 8'h05, 8'h03, 1, 0, 1, 0, 8'h00, 8'h00, 0, 9'h000);
    tbl[1]  = mk(0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0, 9'h000);
    tbl[2]  = mk(0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[3]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h05, 8'h03, 1, 9'h008);
    tbl[4]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[5]  = mk(1, 8'h11, 8'h21, 0, 0, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[6]  = mk(1, 8'h12, 8'h22, 0, 1, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[7]  = mk(1, 8'h13, 8'h23, 0, 2, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[8]  = mk(1, 8'h14, 8'h24, 0, 3, 1, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[9]  = mk(1, 8'h15, 8'h25, 0, 4, 0, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[10] = mk(1, 8'h15, 8'h25, 1, 4, 0, 0, 8'h05, 8'h03, 1, 9'h000);
    tbl[11] = mk(1, 8'h15, 8'h25, 1, 3, 1, 0, 8'h11, 8'h21, 2, 9'h000);
    tbl[12] = mk(0, 8'h00, 8'h00, 1, 3, 1, 1, 8'h12, 8'h22, 3, 9'h032);
    tbl[13] = mk(0, 8'h00, 8'h00, 1, 2, 1, 1, 8'h13, 8'h23, 4, 9'h034);
    tbl[14] = mk(0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h14, 8'h24, 5, 9'h036);
    tbl[15] = mk(0, 8'h00, 8'h00, 1, 0, 1, 1, 8'h15, 8'h25, 6, 9'h038);
    tbl[16] = mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h15, 8'h25, 6, 9'h03A);
    tbl[17] = mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h15, 8'h25, 6, 9'h000);
    tbl[18] = mk(1, 8'hFF, 8'hFF, 1, 0, 1, 0, 8'h15, 8'h25, 6, 9'h000);
    tbl[19] = mk(1, 8'h80, 8'h80, 1, 1, 1, 0, 8'h15, 8'h25, 6, 9'h000);
    tbl[20] = mk(0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hFF, 8'hFF, 7, 9'h000);
    tbl[21] = mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h80, 8'h80, 8, 9'h1FE);
    tbl[22] = mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h80, 8'h80, 8, 9'h100);
    tbl[23] = mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h80, 8'h80, 8, 9'h000);

    reset = 1'b0;
    drive(0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_b", 32'(B), 32'd0);
    chk("rst_sv", 32'(sum_valid), 32'd0);
    chk("rst_iss", 32'(issued_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].ie);
      half();
      chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_sv", i), 32'(sum_valid), 32'(tbl[i].sv));
      chk($sformatf("row%0d_a", i), 32'(A), 32'(tbl[i].ea));
      chk($sformatf("row%0d_b", i), 32'(B), 32'(tbl[i].eb));
      chk($sformatf("row%0d_iss", i), 32'(issued_cnt), 32'(tbl[i].iss));
      if (tbl[i].sv) chk($sformatf("row%0d_sum", i), 32'(sum), 32'(tbl[i].sm));
      fin();
    end

    // Steady push+pop at occupancy 2, running the pointers around several times.
    drive(1, 8'h31, 8'h41, 0); cyc();
    drive(1, 8'h32, 8'h42, 0); cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h50 + i), 8'(8'h60 + i), 1);
      half();
      chk("t4_count", 32'(count), 32'd2);
      fin();
    end
    drive(0, 8'h00, 8'h00, 1); cyc(); cyc();
    drive(0, 8'h00, 8'h00, 0); cyc(); cyc(); cyc();
    chk("t4_drain", 32'(sbq.size()), 32'd0);
    chk("t4_count_end", 32'(count), 32'd0);

    // Reset with three pairs buffered and two sum_valid pulses in flight.
    drive(1, 8'h71, 8'h81, 0); cyc();
    drive(1, 8'h72, 8'h82, 0); cyc();
    drive(1, 8'h73, 8'h83, 0); cyc();
    drive(1, 8'h74, 8'h84, 1); cyc();
    drive(1, 8'h75, 8'h85, 1);
    half();
    chk("t5_count_pre", 32'(count), 32'd3);
    fin();
    reset = 1'b0;
    drive(0, 8'h00, 8'h00, 0);
    #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_a", 32'(A), 32'd0);
    chk("t5_b", 32'(B), 32'd0);
    chk("t5_iss", 32'(issued_cnt), 32'd0);
    chk("t5_sv", 32'(sum_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half();
      chk("t5_no_sv", 32'(sum_valid), 32'd0);
      chk("t5_count_idle", 32'(count), 32'd0);
      fin();
    end
    drive(1, 8'h9A, 8'h9B, 1); cyc();
    drive(0, 8'h00, 8'h00, 1); cyc();
    drive(0, 8'h00, 8'h00, 0); cyc(); cyc(); cyc();
    chk("t5_drain", 32'(sbq.size()), 32'd0);
    chk("t5_iss_after", 32'(issued_cnt), 32'd1);

    // 65537 issues wrap the 16-bit counter to 1; then issue_en on an empty FIFO.
    reset = 1'b0;
    drive(0, 8'h00, 8'h00, 0);
    cyc();
    reset = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
    for (int n = 0; n < 65537; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive(1, ra, rb, 1);
      cyc();
      last_a = ra;
      last_b = rb;
    end
    drive(0, 8'h00, 8'h00, 1);
    cyc();
    half();
    chk("t6_iss_wrap", 32'(issued_cnt), 32'd1);
    chk("t6_count", 32'(count), 32'd0);
    fin();
    cyc(); cyc();
    half();
    chk("t6_empty_a", 32'(A), 32'(last_a));
    chk("t6_empty_b", 32'(B), 32'(last_b));
    chk("t6_empty_sv", 32'(sum_valid), 32'd0);
    chk("t6_empty_iss", 32'(issued_cnt), 32'd1);
    chk("t6_empty_count", 32'(count), 32'd0);
    fin();
    drive(0, 8'h00, 8'h00, 0);
    cyc();
    chk("final_drain", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_operand_issuer.md
Name: adder_operand_issuer

Overview:
- Upstream stage of the 8-bit registered adder.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Drives the adder's A/B inputs from registers, one pair per issue.
- Emits sum_valid aligned with the cycle in which the adder's registered sum reflects each issued pair, so downstream logic knows which sums are real.

Parameters:
- WIDTH, 8, operand width; must equal the adder operand width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- LAT, 1, adder latency in clocks from A/B change to sum update.

Ports:
- clk  input  1  rising-edge clock shared with the adder.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_a/in_b is offered.
- in_ready  output  1  FIFO can accept a pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- issue_en  input  1  permits popping one pair this cycle.
- A  output  WIDTH  registered operand A to the adder.
- B  output  WIDTH  registered operand B to the adder.
- sum_valid  output  1  adder sum output holds the result of an issued pair.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_cnt  output  16  number of pairs issued since reset; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, count=0, A=0, B=0.
  - Delay line cleared, sum_valid=0, issued_cnt=0.
  - in_ready=0 while reset is low.
  - Deassertion of reset is taken synchronously to clk.
- in_ready = (count < DEPTH), decoded from the registered count. A pop in the same cycle does not free a slot.
- push = in_valid & in_ready. On push, {in_a, in_b} is written at the tail, and the tail pointer increments modulo DEPTH.
- pop = issue_en & (count != 0). On pop:
  - A/B are loaded from the head at the clock edge.
  - The head pointer increments modulo DEPTH.
  - issued_cnt increments, wrapping 0xFFFF -> 0.
- With no pop, A/B hold their last values. The adder keeps recomputing the same sum, and sum_valid stays 0 for those cycles.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- No bypass: a pair pushed into an empty FIFO is issued no earlier than the next cycle.
- Pointers are log2(DEPTH) bits with natural wrap. Full/empty is decided by count alone.
- sum_valid timing:
  - sum_valid is the pop strobe delayed through a shift register of LAT+1 stages.
  - With LAT=1, a pop in cycle t puts A/B on the ports in t+1, and the adder sum is visible in t+2. sum_valid is 1 exactly in cycle t+2.
  - Back-to-back pops give back-to-back sum_valid.
- Boundary cases:
  - Full (count=DEPTH): in_ready=0 and in_valid is ignored with no data loss. The upstream source must hold the pair.
  - Empty with issue_en=1: no pop; A/B, issued_cnt and count are unchanged.
- Reset mid-operation:
  - FIFO contents and in-flight sum_valid bits are discarded immediately.
  - No sum_valid pulse may appear after reset for a pair issued before it.
- Adder reset: the adder's reset is active-high synchronous, so the integrating top drives it with the inverse of this block's reset.
- Arithmetic: this block does no arithmetic. The downstream sum is WIDTH+1 bits and carries the carry-out.

Test Plan:
1. Reset then single push of A=8'h05, B=8'h03 with issue_en=1:
   - Pair is pushed in cycle 0 and popped in cycle 1.
   - A=5, B=3 from cycle 2.
   - sum_valid=1 only in cycle 3, with adder sum=9'h008; issued_cnt=1.
2. Push 4 pairs with issue_en=0:
   - count=4, in_ready=0.
   - A 5th in_valid is held and not lost.
   - Raising issue_en pops 4 pairs in order over 4 consecutive cycles, giving 4 consecutive sum_valid pulses.
   - The 5th pair is accepted only after the first pop has lowered count.
3. Carry case, pair FF+FF:
   - Aligned sum_valid cycle shows sum=9'h1FE.
   - Pair 80+80 shows sum=9'h100.
4. Simultaneous push and pop at count=2 for 10 cycles:
   - count stays 2.
   - Issue order equals push order, including across pointer wrap.
5. Assert reset for 1 cycle while 3 pairs are buffered and 2 sum_valid pulses are in flight:
   - count=0, A=B=0 and issued_cnt=0 immediately.
   - No sum_valid afterwards until new pairs are issued.
6. Issue 65537 pairs: issued_cnt reads 1. Also, issue_en=1 on an empty FIFO leaves A/B unchanged and sum_valid=0.
